// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // Which requester a tracked read belongs to.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  // RV32 access size/sign encodings as seen on funct3.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam logic [2:0] FUNCT3_LB   = 3'b000;
  localparam logic [2:0] FUNCT3_LH   = 3'b001;
  localparam logic [2:0] FUNCT3_LW   = 3'b010;
  localparam logic [2:0] FUNCT3_LBU  = 3'b100;
  localparam logic [2:0] FUNCT3_LHU  = 3'b101;
  localparam logic [2:0] FUNCT3_SB   = 3'b000;
  localparam logic [2:0] FUNCT3_SH   = 3'b001;
  localparam logic [2:0] FUNCT3_SW   = 3'b010;

  // Width of the data-grant streak counter.
  localparam int unsigned STREAK_W = 4;

  // Owner tag for a granted request: data wins whenever it holds the grant.
  function automatic owner_t grant_owner(input logic d_granted);
    return d_granted ? OWNER_D : OWNER_IF;
  endfunction

endpackage

// File: rtl/mem_arb_resp_tracker.sv
// Fixed-latency tracker of outstanding reads: one {valid, owner} slot per memory
// pipeline stage, so the tail slot lines up with read_data.
module mem_arb_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  owner_t i_owner,
  output logic   o_tail_valid,
  output owner_t o_tail_owner
);

  logic   r_valid [DEPTH];
  owner_t r_owner [DEPTH];

  // Shift every cycle; slot 0 takes this cycle's granted read (or a bubble).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_owner[i] <= OWNER_IF;
      end
    end else begin
      r_valid[0] <= i_push;
      r_owner[0] <= i_owner;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_owner[i] <= r_owner[i-1];
      end
    end
  end

  assign o_tail_valid = r_valid[DEPTH-1];
  assign o_tail_owner = r_owner[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared between instruction fetch and load/store.
// Data has priority; a streak counter forces a fetch grant after MAX_DATA_STREAK
// consecutive data grants while fetch waits. Read responses are steered back to
// their owner by a fixed-latency tracker.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_DATA_STREAK = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory side
  output logic        write_mem,
  output logic [2:0]  funct3,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic [31:0] read_address,
  input  logic [31:0] read_data
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_next;
  logic                w_if_gnt;
  logic                w_d_gnt;
  logic                w_read_push;
  owner_t              w_push_owner;
  logic                w_tail_valid;
  owner_t              w_tail_owner;
  logic                w_if_resp;
  logic                w_d_resp;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_d_rdata;

  // Grant decision: data first unless fetch has waited out the streak limit.
  always_comb begin
    w_d_gnt  = rst_n & d_req & ~(if_req & (r_streak == STREAK_LIMIT));
    w_if_gnt = rst_n & if_req & ~w_d_gnt;
  end

  // Streak only counts data grants that made fetch wait.
  always_comb begin
    w_streak_next = r_streak;
    if (!if_req || w_if_gnt) begin
      w_streak_next = '0;
    end else if (w_d_gnt) begin
      w_streak_next = r_streak + 1'b1;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_next;
    end
  end

  // Memory-side signals follow the granted request; idle drives a quiet word read.
  always_comb begin
    write_mem     = 1'b0;
    funct3        = FUNCT3_WORD;
    write_address = '0;
    write_data    = '0;
    read_address  = '0;
    if (w_d_gnt) begin
      funct3 = d_funct3;
      if (d_we) begin
        write_mem     = 1'b1;
        write_address = d_addr;
        write_data    = d_wdata;
      end else begin
        read_address = d_addr;
      end
    end else if (w_if_gnt) begin
      read_address = if_addr;
    end
  end

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;

  // Stores never occupy a tracker slot, so they can never produce a response.
  assign w_read_push  = w_if_gnt | (w_d_gnt & ~d_we);
  assign w_push_owner = grant_owner(w_d_gnt);

  mem_arb_resp_tracker #(
    .DEPTH (MEM_LATENCY)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_read_push),
    .i_owner      (w_push_owner),
    .o_tail_valid (w_tail_valid),
    .o_tail_owner (w_tail_owner)
  );

  assign w_if_resp = w_tail_valid & (w_tail_owner == OWNER_IF);
  assign w_d_resp  = w_tail_valid & (w_tail_owner == OWNER_D);

  // Hold registers keep the last response; cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_resp) r_if_rdata <= read_data;
      if (w_d_resp)  r_d_rdata  <= read_data;
    end
  end

  // Response cycle forwards live memory data so latency stays at MEM_LATENCY.
  always_comb begin
    if_rvalid = w_if_resp;
    d_rvalid  = w_d_resp;
    if_rdata  = w_if_resp ? read_data : r_if_rdata;
    d_rdata   = w_d_resp  ? read_data : r_d_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at latency 3,
// both with a streak limit of 3, fed the same request stimulus.
module tb_mem_port_arbiter;

  typedef logic [255:0] wide_t;

  typedef struct packed {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dwe;
    logic [2:0]  df3;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        ifg;
    logic        dg;
    logic        wm;
    logic [2:0]  f3;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        ifv;
    logic [31:0] ifd;
    logic        dv;
    logic [31:0] dd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, write_mem_1;
  logic [31:0] if_rdata_1, d_rdata_1, write_address_1, write_data_1, read_address_1;
  logic [31:0] read_data_1;
  logic [2:0]  funct3_1;
  logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, write_mem_3;
  logic [31:0] if_rdata_3, d_rdata_3, write_address_3, write_data_3, read_address_3;
  logic [31:0] read_data_3;
  logic [2:0]  funct3_3;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs [19];
  logic        t5_ifr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] t5_addr [4] = '{32'h110, 32'h230, 32'h114, 32'h234};
  logic [1:0]  t5_gnt  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [1:0]  t5_rv   [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
  logic [31:0] t5_data [8] = '{32'h0, 32'h0, 32'h0, 32'hA5A50110, 32'hA5A50230,
                               32'hA5A50114, 32'hA5A50234, 32'h0};
  logic [1:0]  t6_gnt  [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  // Memory model: word at address a is a ^ 0xA5A50000, except one fixed instruction.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a ^ 32'hA5A50000);
  endfunction

  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1    <= read_address_1;
    pipe3[0] <= read_address_3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign read_data_1 = mem_data(pipe1);
  assign read_data_3 = mem_data(pipe3[2]);

  mem_port_arbiter #(
    .MEM_LATENCY     (1),
    .MAX_DATA_STREAK (3)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_gnt        (if_gnt_1),
    .if_rvalid     (if_rvalid_1),
    .if_rdata      (if_rdata_1),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_funct3      (d_funct3),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_gnt         (d_gnt_1),
    .d_rvalid      (d_rvalid_1),
    .d_rdata       (d_rdata_1),
    .write_mem     (write_mem_1),
    .funct3        (funct3_1),
    .write_address (write_address_1),
    .write_data    (write_data_1),
    .read_address  (read_address_1),
    .read_data     (read_data_1)
  );

  mem_port_arbiter #(
    .MEM_LATENCY     (3),
    .MAX_DATA_STREAK (3)
  ) dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_gnt        (if_gnt_3),
    .if_rvalid     (if_rvalid_3),
    .if_rdata      (if_rdata_3),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_funct3      (d_funct3),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_gnt         (d_gnt_3),
    .d_rvalid      (d_rvalid_3),
    .d_rdata       (d_rdata_3),
    .write_mem     (write_mem_3),
    .funct3        (funct3_3),
    .write_address (write_address_3),
    .write_data    (write_data_3),
    .read_address  (read_address_3),
    .read_data     (read_data_3)
  );

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr,
                       input logic dwe, input logic [2:0] df3, input logic [31:0] da,
                       input logic [31:0] dwd);
    if_req   = ifr;
    if_addr  = ifa;
    d_req    = dr;
    d_we     = dwe;
    d_funct3 = df3;
    d_addr   = da;
    d_wdata  = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ifr ifa dr dwe df3 da dwd | ifg dg wm f3 ra wa wd | ifv ifd dv dd
    vecs[0]  = '{1, 32'h100, 0, 0, 3'b010, 0, 0, 1, 0, 0, 3'b010, 32'h100, 0, 0,
                 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0,
                 1, 32'h00500093, 0, 0};
    vecs[2]  = '{1, 32'h104, 1, 0, 3'b010, 32'h200, 0, 0, 1, 0, 3'b010, 32'h200, 0, 0,
                 0, 32'h00500093, 0, 0};
    vecs[3]  = '{1, 32'h104, 0, 0, 3'b010, 32'h200, 0, 1, 0, 0, 3'b010, 32'h104, 0, 0,
                 0, 32'h00500093, 1, 32'hA5A50200};
    vecs[4]  = '{0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0,
                 1, 32'hA5A50104, 0, 32'hA5A50200};
    vecs[5]  = '{0, 0, 1, 1, 3'b010, 32'h300, 32'hDEADBEEF, 0, 1, 1, 3'b010, 0, 32'h300,
                 32'hDEADBEEF, 0, 32'hA5A50104, 0, 32'hA5A50200};
    vecs[6]  = '{0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0,
                 0, 32'hA5A50104, 0, 32'hA5A50200};
    vecs[7]  = '{0, 0, 1, 0, 3'b100, 32'h208, 0, 0, 1, 0, 3'b100, 32'h208, 0, 0,
                 0, 32'hA5A50104, 0, 32'hA5A50200};
    vecs[8]  = '{0, 0, 1, 1, 3'b000, 32'h30C, 32'hAB, 0, 1, 1, 3'b000, 0, 32'h30C, 32'hAB,
                 0, 32'hA5A50104, 1, 32'hA5A50208};
    vecs[9]  = '{0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0,
                 0, 32'hA5A50104, 0, 32'hA5A50208};
    vecs[10] = '{1, 32'h108, 1, 0, 3'b010, 32'h210, 0, 0, 1, 0, 3'b010, 32'h210, 0, 0,
                 0, 32'hA5A50104, 0, 32'hA5A50208};
    vecs[11] = '{1, 32'h108, 1, 0, 3'b010, 32'h214, 0, 0, 1, 0, 3'b010, 32'h214, 0, 0,
                 0, 32'hA5A50104, 1, 32'hA5A50210};
    vecs[12] = '{1, 32'h108, 1, 0, 3'b010, 32'h218, 0, 0, 1, 0, 3'b010, 32'h218, 0, 0,
                 0, 32'hA5A50104, 1, 32'hA5A50214};
    vecs[13] = '{1, 32'h108, 1, 0, 3'b010, 32'h21C, 0, 1, 0, 0, 3'b010, 32'h108, 0, 0,
                 0, 32'hA5A50104, 1, 32'hA5A50218};
    vecs[14] = '{1, 32'h10C, 1, 0, 3'b010, 32'h21C, 0, 0, 1, 0, 3'b010, 32'h21C, 0, 0,
                 1, 32'hA5A50108, 0, 32'hA5A50218};
    vecs[15] = '{1, 32'h10C, 1, 0, 3'b010, 32'h220, 0, 0, 1, 0, 3'b010, 32'h220, 0, 0,
                 0, 32'hA5A50108, 1, 32'hA5A5021C};
    vecs[16] = '{1, 32'h10C, 1, 0, 3'b010, 32'h224, 0, 0, 1, 0, 3'b010, 32'h224, 0, 0,
                 0, 32'hA5A50108, 1, 32'hA5A50220};
    vecs[17] = '{1, 32'h10C, 1, 0, 3'b010, 32'h228, 0, 1, 0, 0, 3'b010, 32'h10C, 0, 0,
                 0, 32'hA5A50108, 1, 32'hA5A50224};
    vecs[18] = '{0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0,
                 1, 32'hA5A5010C, 0, 32'hA5A50224};

    // Reset: requests present but grants and write strobe forced low.
    rst_n = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 3'b010, 32'h300, 32'h1234);
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset_gnt_l1", wide_t'({if_gnt_1, d_gnt_1, write_mem_1}), wide_t'(3'b000));
    check("reset_gnt_l3", wide_t'({if_gnt_3, d_gnt_3, write_mem_3}), wide_t'(3'b000));
    check("reset_resp_l1", wide_t'({if_rvalid_1, d_rvalid_1, if_rdata_1, d_rdata_1}),
          wide_t'(0));

    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_mem_side", wide_t'({write_mem_1, funct3_1, write_address_1, write_data_1,
                                    read_address_1}), wide_t'({1'b0, 3'b010, 96'h0}));

    // Table: single-cycle function, routing, stores, and the D,D,D,F streak pattern.
    for (int i = 0; i < 19; i++) begin
      next_cycle();
      drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dr, vecs[i].dwe, vecs[i].df3, vecs[i].da,
            vecs[i].dwd);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            wide_t'({if_gnt_1, d_gnt_1, write_mem_1, funct3_1, read_address_1,
                     write_address_1, write_data_1, if_rvalid_1, if_rdata_1, d_rvalid_1,
                     d_rdata_1}),
            wide_t'({vecs[i].ifg, vecs[i].dg, vecs[i].wm, vecs[i].f3, vecs[i].ra,
                     vecs[i].wa, vecs[i].wd, vecs[i].ifv, vecs[i].ifd, vecs[i].dv,
                     vecs[i].dd}));
    end

    // Drain the latency-3 pipeline.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (4) next_cycle();

    // Latency 3: alternating F,D,F,D reads, responses in grant order.
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      if (c < 4) begin
        if (t5_ifr[c]) drive(1'b1, t5_addr[c], 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        else           drive(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, t5_addr[c], 32'h0);
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
      end
      @(negedge clk);
      if (c < 4) begin
        check($sformatf("l3_gnt_c%0d", c), wide_t'({if_gnt_3, d_gnt_3}), wide_t'(t5_gnt[c]));
      end
      check($sformatf("l3_rvalid_c%0d", c), wide_t'({if_rvalid_3, d_rvalid_3}),
            wide_t'(t5_rv[c]));
      if (t5_rv[c] == 2'b10) begin
        check($sformatf("l3_if_rdata_c%0d", c), wide_t'(if_rdata_3), wide_t'(t5_data[c]));
      end
      if (t5_rv[c] == 2'b01) begin
        check($sformatf("l3_d_rdata_c%0d", c), wide_t'(d_rdata_3), wide_t'(t5_data[c]));
      end
    end

    // Reset with reads in flight: build streak to 2, then reset for 2 cycles.
    next_cycle();
    drive(1'b1, 32'h118, 1'b1, 1'b0, 3'b010, 32'h23C, 32'h0);
    @(negedge clk);
    check("pre_rst_gnt_a", wide_t'({if_gnt_3, d_gnt_3}), wide_t'(2'b01));
    next_cycle();
    drive(1'b1, 32'h118, 1'b1, 1'b0, 3'b010, 32'h240, 32'h0);
    @(negedge clk);
    check("pre_rst_gnt_b", wide_t'({if_gnt_3, d_gnt_3}), wide_t'(2'b01));
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 32'h118, 1'b1, 1'b1, 3'b010, 32'h244, 32'h55);
    @(negedge clk);
    check("rst_gnt_both", wide_t'({if_gnt_1, d_gnt_1, write_mem_1, if_gnt_3, d_gnt_3,
                                   write_mem_3}), wide_t'(6'b0));
    next_cycle();
    @(negedge clk);
    check("rst_gnt_both_2", wide_t'({if_gnt_1, d_gnt_1, write_mem_1, if_gnt_3, d_gnt_3,
                                     write_mem_3}), wide_t'(6'b0));
    check("rst_clears_rdata", wide_t'({if_rvalid_3, d_rvalid_3, if_rdata_3, d_rdata_3}),
          wide_t'(0));
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_rvalid_c%0d", c),
            wide_t'({if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3}), wide_t'(4'b0));
      next_cycle();
    end

    // Streak restarted from 0: expect D,D,D,F,D on both instances.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h11C, 1'b1, 1'b0, 3'b010, 32'h250 + 32'(4 * c), 32'h0);
      @(negedge clk);
      check($sformatf("post_rst_streak_c%0d", c),
            wide_t'({if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3}),
            wide_t'({t6_gnt[c], t6_gnt[c]}));
      next_cycle();
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (4) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between the instruction-fetch path and the load/store path of the RV32 core controller. Accepts one request per cycle from either requester via req/gnt handshake and drives the memory-side write_mem/funct3/address/data signals. Tracks in-flight reads so each read response returns only to its owner. Data accesses take priority, and a streak counter prevents fetch starvation.

Parameters:
MEM_LATENCY, 1, cycles from read_address presented to read_data valid; legal range 1..4
MAX_DATA_STREAK, 3, consecutive data grants allowed while fetch is waiting before fetch is forced; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; always a word read
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  32  fetch read data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  RV32 access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  32  load data
write_mem  out  1  memory write strobe
funct3  out  3  memory access size
write_address  out  32  memory write address
write_data  out  32  memory write data
read_address  out  32  memory read address
read_data  in  32  memory read data, valid MEM_LATENCY cycles after read_address

Behaviour:
- Handshake: a requester holds req and all fields stable until it samples gnt=1. A transfer occurs on a cycle where req && gnt. gnt is combinational from req and arbiter state. At most one gnt per cycle.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active: d granted unless streak == MAX_DATA_STREAK, in which case if granted.
  - streak (4 bits, reset 0) increments on each d grant while if_req=1. It clears on any if grant and on any cycle with if_req=0.
- Memory outputs are combinational from the granted request:
  - Fetch grant: read_address = if_addr, funct3 = 3'b010, write_mem = 0.
  - Data load: read_address = d_addr, funct3 = d_funct3, write_mem = 0.
  - Data store: write_mem = 1, write_address = d_addr, write_data = d_wdata, funct3 = d_funct3.
  - No grant: write_mem = 0, funct3 = 3'b010, all addresses and write_data = 0.
- Stores produce no response. d_rvalid is never raised for a store.
- Response tracking:
  - A MEM_LATENCY-deep shift register of {valid, owner} is shifted every cycle. The entry is loaded on each granted read.
  - When the tail entry is valid, read_data is routed to the owner's rdata and that owner's rvalid is high for exactly 1 cycle.
  - Latency from grant cycle to rvalid is exactly MEM_LATENCY cycles.
  - Responses are in grant order. Back-to-back reads are fully pipelined at 1 per cycle.
  - if_rvalid and d_rvalid are never both high in the same cycle.
- rdata outputs are registered in the response stage and hold their last value when rvalid=0.
- Reset (rst_n=0 sampled at a rising edge):
  - Tracker is cleared, streak = 0, if_rvalid = d_rvalid = 0, if_rdata = d_rdata = 0.
  - While rst_n=0, both gnt are forced to 0 and write_mem to 0.
  - Reads in flight at reset never produce rvalid, including reads whose data arrives after reset deasserts.
- Simultaneous grant and response in one cycle is legal; they are independent.

Decomposition:
- Package mem_arb_pkg:
  - enum owner_t {OWNER_IF, OWNER_D}
  - FUNCT3_WORD = 3'b010
  - funct3 constants for LB/LH/LW/LBU/LHU/SB/SH/SW
- Sub-module mem_arb_resp_tracker: parameterized shift register of {valid, owner_t}. Inputs: push, owner. Outputs: tail valid and tail owner. Reset-clearable.

Test Plan:
1. MEM_LATENCY=1, if_req=1 only, if_addr=0x100, memory returns 0x00500093 -> if_gnt=1 same cycle, read_address=0x100, funct3=010; next cycle if_rvalid=1, if_rdata=0x00500093, d_rvalid=0.
2. if_req and d_req (load, d_addr=0x200, funct3=010) asserted together -> d_gnt in cycle 0, if_gnt in cycle 1; d_rvalid in cycle 1 and if_rvalid in cycle 2, each with its own address's data.
3. Store d_we=1, d_addr=0x300, d_wdata=0xDEADBEEF, d_funct3=010 -> write_mem=1, write_address=0x300, write_data=0xDEADBEEF for 1 cycle; no d_rvalid ever.
4. MAX_DATA_STREAK=3, both requesting continuously -> grant sequence D,D,D,F,D,D,D,F; streak returns to 0 after each F.
5. MEM_LATENCY=3, alternating F,D,F,D reads back-to-back -> rvalid sequence if,d,if,d starting 3 cycles after the first grant, with data matching each address.
6. Load granted, rst_n=0 on the next edge for 2 cycles -> no d_rvalid at any time afterwards, both gnt=0 during reset, streak=0 after reset.
